// File: rtl/slug_port_pkg.sv
// Shared constants, select-width helper and read-source encoding for the slug_port I/O bank.
package slug_port_pkg;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_CHANNELS = 8;

  // Cycles of change detection masked after reset, matched to the sample path depth
  localparam int WARM_SYNC    = 3;
  localparam int WARM_NOSYNC  = 1;

  typedef enum logic {
    SRC_IN  = 1'b0,
    SRC_OUT = 1'b1
  } rd_src_t;

  function automatic int sel_w(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/slug_port_sync2.sv
// Two-flop synchronizer for the external input bus; both stages clear on synchronous reset.
module slug_sync2
  import slug_port_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage1;
  logic [W-1:0] r_stage2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
    end else begin
      r_stage1 <= i_d;
      r_stage2 <= r_stage1;
    end
  end

  assign o_q = r_stage2;

endmodule

// File: rtl/slug_port.sv
// Parametrised output register bank plus sampled inputs with sticky change flags and masked irq.
// Optional input synchronizer enabled by defining SLUG_PORT_SYNC_EN.
module slug_port
  import slug_port_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = sel_w(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       rd,
  input  logic                       rd_src,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rdata,
  input  logic [CHANNELS*DATA_W-1:0] port_in,
  output logic [CHANNELS*DATA_W-1:0] port_out,
  output logic [CHANNELS-1:0]        out_stb,
  input  logic [CHANNELS-1:0]        irq_en,
  output logic [CHANNELS-1:0]        chg,
  output logic                       irq
);

`ifdef SLUG_PORT_SYNC_EN
  localparam int WARM = WARM_SYNC;
`else
  localparam int WARM = WARM_NOSYNC;
`endif
  localparam int BUS_W   = CHANNELS * DATA_W;
  localparam int WARM_CW = $clog2(WARM + 1);

  logic [BUS_W-1:0]    w_sample;
  logic [BUS_W-1:0]    r_prevSample;
  logic [BUS_W-1:0]    r_portOut;
  logic [CHANNELS-1:0] w_selHot;
  logic [CHANNELS-1:0] w_detect;
  logic [CHANNELS-1:0] w_clear;
  logic [CHANNELS-1:0] r_outStb;
  logic [CHANNELS-1:0] r_chg;
  logic [DATA_W-1:0]   w_rdMux;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rdValid;
  logic                r_irq;
  logic                w_readIn;
  logic                w_warmDone;
  logic [WARM_CW-1:0]  r_warm;

`ifdef SLUG_PORT_SYNC_EN
  slug_sync2 #(.W(BUS_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (port_in),
    .o_q (w_sample)
  );
`else
  assign w_sample = port_in;
`endif

  // One-hot select decode; an out-of-range select yields all zeros, so it neither writes nor reads
  always_comb begin
    w_selHot = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_selHot[k] = (sel == SEL_W'(k));
    end
  end

  assign w_readIn   = (rd_src_t'(rd_src) == SRC_IN);
  assign w_warmDone = (r_warm == WARM_CW'(WARM));
  assign w_clear    = (rd && w_readIn) ? w_selHot : '0;

  always_comb begin
    w_rdMux = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_selHot[k]) begin
        w_rdMux = w_readIn ? w_sample[k*DATA_W +: DATA_W] : r_portOut[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_detect = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_detect[k] = w_warmDone &&
                    (w_sample[k*DATA_W +: DATA_W] != r_prevSample[k*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_portOut <= '0;
      r_outStb  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr && w_selHot[k]) begin
          r_portOut[k*DATA_W +: DATA_W] <= wdata;
        end
      end
      r_outStb <= wr ? w_selHot : '0;
    end
  end

  // Read data reflects pre-edge state, so a write at the same edge is not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdValid <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rdValid <= rd;
      if (rd) begin
        r_rdata <= w_rdMux;
      end
    end
  end

  // A fresh change at the same edge as a clearing read wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevSample <= '0;
      r_chg        <= '0;
      r_irq        <= 1'b0;
      r_warm       <= '0;
    end else begin
      r_prevSample <= w_sample;
      r_chg        <= (r_chg & ~w_clear) | w_detect;
      r_irq        <= |(r_chg & irq_en);
      if (!w_warmDone) begin
        r_warm <= r_warm + WARM_CW'(1);
      end
    end
  end

  assign port_out = r_portOut;
  assign out_stb  = r_outStb;
  assign rd_valid = r_rdValid;
  assign rdata    = r_rdata;
  assign chg      = r_chg;
  assign irq      = r_irq;

endmodule

// File: doc/slug_port.md
# slug_port

Parametrised I/O port bank for the slug core pipeline, replacing the fixed 8×4-bit output nibble registers and adding the input side. It provides CHANNELS output registers of DATA_W bits with a per-channel write strobe, and CHANNELS sampled input channels with per-channel sticky change flags and a masked interrupt. The block is addressed by the pipeline's select field. Reads return one cycle after the request, which matches the stage-3-request / stage-4-data timing.

## Interface
- DATA_W, 4, bits per channel
- CHANNELS, 8, number of input and output channels (1..16, need not be a power of 2)
- SEL_W, $clog2(CHANNELS) (min 1), select width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- sel  in  SEL_W  channel select for wr and rd
- wr  in  1  write port_out[sel] with wdata
- wdata  in  DATA_W  write data
- rd  in  1  read request for channel sel
- rd_src  in  1  0 = input channel, 1 = output register read-back
- rd_valid  out  1  read data valid
- rdata  out  DATA_W  read data
- port_in  in  CHANNELS*DATA_W  external inputs; channel k = [k*DATA_W +: DATA_W]
- port_out  out  CHANNELS*DATA_W  output registers, same packing
- out_stb  out  CHANNELS  one-cycle pulse per channel written
- irq_en  in  CHANNELS  per-channel interrupt enable
- chg  out  CHANNELS  sticky per-channel change flags
- irq  out  1  |(chg & irq_en), registered

## Operation
- Reset values: port_out, rdata, rd_valid, out_stb, chg and irq are all 0. The synchronizer, previous-sample register and warm-up counter are also 0.
- Sample s_k: the synchronized port_in channel (see Configuration).
- Write: when wr=1 at an edge with sel=k<CHANNELS, port_out[k] <= wdata and out_stb[k] = 1 for the following cycle only. Back-to-back writes to the same channel give a strobe on each cycle.
- Read: when rd=1 at an edge with sel=k<CHANNELS:
  - rd_valid = 1 the next cycle.
  - rdata = s_k, or port_out[k] if rd_src=1. This is the value before the edge, so a same-edge write is not visible.
  - rd=0 gives rd_valid=0; rdata holds its last value.
- Out-of-range sel (k>=CHANNELS):
  - A write has no effect and produces no strobe.
  - A read still returns rd_valid=1, with rdata=0.
- Change detect: the previous-sample register p_k <= s_k on every cycle. When s_k != p_k, chg[k] <= 1.
- Clear: a read of channel k with rd_src=0 clears chg[k]. If a new change on channel k is detected at the same edge, set wins and chg[k] stays 1. A read with rd_src=1 does not clear chg.
- Warm-up: after reset deassertion, change detection is suppressed for WARM cycles (3 with sync, 1 without), counted by a saturating counter. This prevents spurious chg bits from the 0→port_in transition.
- irq: registered, so it follows chg by one cycle.
- Reset asserted mid-operation: all state returns to reset values at that edge, pending read data is discarded, and warm-up restarts.

## Timing
- Write to port_out visible: 1 edge. out_stb is asserted in the same cycle port_out updates.
- Read request to rd_valid/rdata: 1 edge, fully pipelined, one read per cycle.
- With SLUG_PORT_SYNC_EN, port_in change to:
  - s: 2 edges
  - chg: 3 edges
  - irq: 4 edges
- Without SLUG_PORT_SYNC_EN, port_in change to:
  - s: 0 edges (combinational)
  - chg: 1 edge
  - irq: 2 edges

## Configuration
- SLUG_PORT_SYNC_EN defined: each input bit goes through a 2-flop synchronizer, reset to 0. WARM = 3.
- SLUG_PORT_SYNC_EN undefined: s = port_in directly, which is only for synchronous, on-chip sources. WARM = 1.

## Structure
- Package slug_port_pkg holds:
  - DEF_DATA_W, DEF_CHANNELS
  - function sel_w(channels) returning max(1, clog2)
  - typedef enum logic {SRC_IN, SRC_OUT} rd_src_t
  - WARM_SYNC = 3, WARM_NOSYNC = 1
- Sub-module slug_sync2 (parameter W) is the 2-flop synchronizer. It is instantiated once over the full port_in bus, only under the macro.
- Everything else lives in slug_port: the output register array, strobe flops, read mux/register, change detect, warm-up counter and irq.

## Test plan
- Reset with port_in = 32'hFFFF_FFFF, hold for 10 cycles -> chg = 0, irq = 0, port_out = 0, rd_valid = 0.
- wr sel=3 wdata=4'hA; next cycle wr sel=3 wdata=4'h5 -> port_out[15:12] = A then 5; out_stb = 8'h08 for 2 cycles; other channels remain 0.
- port_in[7:4] changes 0→6 with irq_en = 8'h02 -> chg = 8'h02 and irq = 1 after the latency set by the macro; rd sel=1 rd_src=0 -> rdata = 6, rd_valid = 1; chg and irq clear the cycle after.
- rd sel=2 rd_src=1 and wr sel=2 wdata=9 at the same edge, with port_out[11:8] = 4 beforehand -> rdata = 4, and port_out[11:8] = 9 after the edge.
- CHANNELS=5: wr sel=7 -> no port_out change, out_stb = 0; rd sel=6 -> rd_valid = 1, rdata = 0.
- Input change on channel 0 at the same edge as a channel-0 read (rd_src=0) -> chg[0] stays 1. Reset asserted while rd is pending -> rd_valid = 0 and warm-up restarts.
